// File: rtl/iter_alu.sv
// Multi-cycle ALU for the EX stage: single-cycle logic/shift ops plus iterative
// radix-2 multiply and restoring divide, behind a valid/ready handshake.
module iter_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_hi
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  state_t           state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] c_q, c_d, c_hi_q, c_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, a_q, a_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d, neg_rem_q, neg_rem_d, bzero_q, bzero_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast_res;
  logic             op_signed;
  logic [WIDTH-1:0] a_abs, b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   div_hi_n, div_lo_n, quo_fix, rem_fix;

  assign shamt     = B[SHW-1:0];
  assign op_signed = ALUOp[0];
  assign a_abs     = (op_signed && A[WIDTH-1]) ? -A : A;
  assign b_abs     = (op_signed && B[WIDTH-1]) ? -B : B;

  always_comb begin
    fast_res = '0;
    case (ALUOp)
      4'b0000: fast_res = A + B;
      4'b0001: fast_res = A - B;
      4'b0010: fast_res = A & B;
      4'b0011: fast_res = A | B;
      4'b0100: fast_res = A >> shamt;
      4'b0101: fast_res = $signed(A) >>> shamt;
      4'b0110: fast_res = A << shamt;
      4'b0111: fast_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      default: fast_res = '0;
    endcase
  end

  // One iteration of each algorithm on magnitudes; hi holds the partial
  // product / partial remainder, lo the multiplier / dividend-quotient.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    prod      = {mul_hi_n, mul_lo_n};
    prod_fix  = neg_q ? -prod : prod;

    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_ok    = !div_trial[WIDTH];
    div_hi_n  = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_n  = {lo_q[WIDTH-2:0], div_ok};
    quo_fix   = neg_q ? -div_lo_n : div_lo_n;
    rem_fix   = neg_rem_q ? -div_hi_n : div_hi_n;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    c_hi_d    = c_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (ALUOp[3:2] == 2'b10) begin
            state_d   = BUSY;
            cnt_d     = CNT_LOAD;
            hi_d      = '0;
            lo_d      = a_abs;
            opnd_d    = b_abs;
            a_d       = A;
            is_div_d  = ALUOp[1];
            neg_d     = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem_d = op_signed & A[WIDTH-1];
            bzero_d   = (B == '0);
          end else begin
            state_d = DONE;
            c_d     = fast_res;
            c_hi_d  = '0;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        hi_d  = is_div_q ? div_hi_n : mul_hi_n;
        lo_d  = is_div_q ? div_lo_n : mul_lo_n;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          if (!is_div_q) begin
            c_d    = prod_fix[WIDTH-1:0];
            c_hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end else if (bzero_q) begin
            c_d    = '1;
            c_hi_d = a_q;
          end else begin
            c_d    = quo_fix;
            c_hi_d = rem_fix;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over accept and completion; the last result stays on C/C_hi.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      c_d     = c_q;
      c_hi_d  = c_hi_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      c_q       <= '0;
      c_hi_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      c_hi_q    <= c_hi_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign C         = c_q;
  assign C_hi      = c_hi_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed-vector bench for iter_alu (WIDTH=32): one task per scenario, each
// with its own inline comparisons against hand-computed values.
module tb_iter_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   ALUOp = 4'h0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] C, C_hi;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] hi;
  } vec_t;

  iter_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .A(A), .B(B), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .C(C), .C_hi(C_hi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one request for exactly one edge, then scrambles the operands
  // so any late sampling by the DUT shows up in the result.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; ALUOp = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUOp = 4'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (C !== '0) begin miscompares++; $display("[TB] FAIL reset_C: got %h expected 0", C); end
    vectors++; if (C_hi !== '0) begin miscompares++; $display("[TB] FAIL reset_C_hi: got %h expected 0", C_hi); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    vec_t v[10];
    v[0] = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0};
    v[1] = '{4'h1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0};
    v[2] = '{4'h2, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 32'h0};
    v[3] = '{4'h3, 32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h0};
    v[4] = '{4'h4, 32'h80000000, 32'h00000024, 32'h08000000, 32'h0};
    v[5] = '{4'h5, 32'h80000000, 32'h00000021, 32'hC0000000, 32'h0};
    v[6] = '{4'h6, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    v[7] = '{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0};
    v[8] = '{4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0};
    v[9] = '{4'hC, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0};
    for (int i = 0; i < 10; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single%0d_latency: out_valid got %b expected 1", i, out_valid); end
      vectors++; if (C !== v[i].c) begin miscompares++; $display("[TB] FAIL single%0d_C: got %h expected %h", i, C, v[i].c); end
      vectors++; if (C_hi !== v[i].hi) begin miscompares++; $display("[TB] FAIL single%0d_C_hi: got %h expected %h", i, C_hi, v[i].hi); end
      consume();
    end
  endtask

  task automatic test_mul();
    vec_t v[5];
    int n;
    v[0] = '{4'h9, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF};
    v[1] = '{4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    v[2] = '{4'h8, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001};
    v[3] = '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    v[4] = '{4'h9, 32'h80000000, 32'h00000002, 32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(n);
      vectors++; if (n !== 32) begin miscompares++; $display("[TB] FAIL mul%0d_cycles: got %0d expected 32", i, n); end
      vectors++; if (C !== v[i].c) begin miscompares++; $display("[TB] FAIL mul%0d_C: got %h expected %h", i, C, v[i].c); end
      vectors++; if (C_hi !== v[i].hi) begin miscompares++; $display("[TB] FAIL mul%0d_C_hi: got %h expected %h", i, C_hi, v[i].hi); end
      consume();
    end
  endtask

  task automatic test_div();
    vec_t v[7];
    int n;
    v[0] = '{4'hB, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
    v[1] = '{4'hA, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005};
    v[2] = '{4'hB, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    v[3] = '{4'hA, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002};
    v[4] = '{4'hB, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    v[5] = '{4'hB, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB};
    v[6] = '{4'hA, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(n);
      vectors++; if (n !== 32) begin miscompares++; $display("[TB] FAIL div%0d_cycles: got %0d expected 32", i, n); end
      vectors++; if (C !== v[i].c) begin miscompares++; $display("[TB] FAIL div%0d_C: got %h expected %h", i, C, v[i].c); end
      vectors++; if (C_hi !== v[i].hi) begin miscompares++; $display("[TB] FAIL div%0d_C_hi: got %h expected %h", i, C_hi, v[i].hi); end
      consume();
    end
  endtask

  // A competing request sits on the inputs while the result is stalled; it
  // must not be taken until the held result has been consumed.
  task automatic test_hold();
    issue(4'h0, 32'd2, 32'd3);
    in_valid = 1'b1; ALUOp = 4'h1; A = 32'd100; B = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++; if (C !== 32'd5) begin miscompares++; $display("[TB] FAIL hold%0d_C: got %h expected 5", i, C); end
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold%0d_handshake: out_valid/in_ready got %b%b expected 10", i, out_valid, in_ready); end
    end
    in_valid = 1'b0;
    consume();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_release: out_valid/in_ready got %b%b expected 01", out_valid, in_ready); end
    issue(4'h1, 32'd100, 32'd1);
    vectors++; if (out_valid !== 1'b1 || C !== 32'd99) begin miscompares++; $display("[TB] FAIL hold_next_op: out_valid %b C %h expected 1 and 00000063", out_valid, C); end
    consume();
  endtask

  task automatic test_flush();
    logic seen;
    issue(4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_busy_state: out_valid/in_ready got %b%b expected 01", out_valid, in_ready); end
    vectors++; if (C !== 32'd99) begin miscompares++; $display("[TB] FAIL flush_busy_C_kept: got %h expected 00000063", C); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_no_result: out_valid seen %b expected 0", seen); end
    in_valid = 1'b1; ALUOp = 4'h0; A = 32'd7; B = 32'd8; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_blocks_accept: out_valid/in_ready got %b%b expected 01", out_valid, in_ready); end
    issue(4'h0, 32'd2, 32'd3);
    vectors++; if (out_valid !== 1'b1 || C !== 32'd5) begin miscompares++; $display("[TB] FAIL flush_followon_add: out_valid %b C %h expected 1 and 00000005", out_valid, C); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++; if (out_valid !== 1'b0 || C !== 32'd5) begin miscompares++; $display("[TB] FAIL flush_done: out_valid %b C %h expected 0 and 00000005", out_valid, C); end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(4'hA, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || C !== '0 || C_hi !== '0) begin miscompares++; $display("[TB] FAIL reset_mid_async: out_valid %b C %h C_hi %h expected 0 0 0", out_valid, C, C_hi); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_release: in_ready/out_valid got %b%b expected 10", in_ready, out_valid); end
    issue(4'hA, 32'd100, 32'd7);
    wait_done(n);
    vectors++; if (n !== 32 || C !== 32'd14 || C_hi !== 32'd2) begin miscompares++; $display("[TB] FAIL reset_mid_rerun: cycles %0d C %h C_hi %h expected 32 0000000e 00000002", n, C, C_hi); end
    consume();
  endtask

  // Consume and accept on consecutive edges (peak rate), and make sure a
  // single-cycle op clears the high half left by a multiply.
  task automatic test_back_to_back();
    int n;
    issue(4'h8, 32'hFFFFFFFF, 32'h00000002);
    wait_done(n);
    vectors++; if (C !== 32'hFFFFFFFE || C_hi !== 32'h1) begin miscompares++; $display("[TB] FAIL b2b_mul: C %h C_hi %h expected fffffffe 00000001", C, C_hi); end
    consume();
    issue(4'h0, 32'd1, 32'd1);
    vectors++; if (out_valid !== 1'b1 || C !== 32'd2 || C_hi !== '0) begin miscompares++; $display("[TB] FAIL b2b_add: out_valid %b C %h C_hi %h expected 1 00000002 0", out_valid, C, C_hi); end
    consume();
    issue(4'h6, 32'd1, 32'd4);
    vectors++; if (out_valid !== 1'b1 || C !== 32'd16) begin miscompares++; $display("[TB] FAIL b2b_sll: out_valid %b C %h expected 1 00000010", out_valid, C); end
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
